pam_mode_ctrl: RTL and testbench
================================

// Module: pam_mode_ctrl
// PURPOSE
//  Parametrised PAM-level selector for the DAC8820EVM symbol path. Debounces the front-panel
//  mode pushbutton and cycles through PAM-2^MIN_BITS .. PAM-2^DATA_W. Switches format only at a
//  frame start, so a frame is never mixed-format. Left-justifies each symbol to the DAC word.
//  Sits between the symbol generator and the DAC serialiser.
// PARAMETERS
//  DATA_W       5   symbol/DAC word width; the top mode uses all DATA_W bits
//  MIN_BITS     2   bits/symbol in mode 0 (1..DATA_W); NUM_MODES = DATA_W-MIN_BITS+1 (localparam)
//  DEBOUNCE_CYC 16  consecutive cycles a changed button level must hold to be accepted (>=1)
//  SYNC_STAGES  2   button synchroniser depth (>=2)
//  APPLY_AT_SOF 1   1: pending mode applied only on sof&din_valid; 0: applied next cycle
// PORTS
//  clk          in   1         system clock
//  rst_n        in   1         asynchronous active-low reset
//  sel          in   1         raw pushbutton, active-low, asynchronous to clk
//  datain       in   DATA_W    symbol, LSB-aligned
//  din_valid    in   1         datain/sof qualifier
//  sof          in   1         start of frame; only meaningful when din_valid=1
//  dataout      out  DATA_W    symbol, MSB-aligned, zero-filled
//  dout_valid   out  1         dataout qualifier
//  mode         out  MODE_W    active mode, MODE_W = $clog2(NUM_MODES) (min 1)
//  mode_pending out  1         requested mode != active mode
//  mode_changed out  1         1-cycle pulse when active mode takes a new value
// BEHAVIOUR
//  Reset (async assert, sync release): sync chain=1, stable=1, db_cnt=0, next_mode=0, mode=0,
//   dataout=0, dout_valid=0, mode_changed=0. Reset mid-frame discards pending requests.
//  Sync: sel passes through SYNC_STAGES flops -> sel_s.
//  Debounce: if sel_s==stable, db_cnt<=0. Otherwise db_cnt increments; when it reaches
//   DEBOUNCE_CYC-1, stable<=sel_s and db_cnt<=0. Stable changes DEBOUNCE_CYC cycles after sel_s
//   settles. A glitch shorter than DEBOUNCE_CYC cycles is ignored.
//  Press event: stable 1->0 only. Release is ignored.
//  next_mode: +1 per press event, wrapping NUM_MODES-1 -> 0. Multiple presses before apply
//   accumulate with wrap.
//  Apply, APPLY_AT_SOF=1: on a cycle with din_valid&sof, mode<=next_mode.
//   A press event in the same cycle updates next_mode only after the apply.
//   The old next_mode value is applied, and mode_pending is then 1.
//  Apply, APPLY_AT_SOF=0: mode<=next_mode every cycle (1-cycle lag).
//  mode_changed: asserts for 1 cycle, in the cycle after mode is loaded with a differing value.
//   It is aligned with dout_valid of the first symbol in the new mode when APPLY_AT_SOF=1.
//  mode_pending: combinational (next_mode != mode).
//  Datapath, latency 1: on din_valid, k = MIN_BITS+m, where m is the mode in effect for this
//   symbol. On a sof symbol that is the newly applied mode. dataout <= {datain[k-1:0],
//   (DATA_W-k)'b0}. datain bits above k-1 are discarded.
//   When din_valid=0: dataout holds its value.
//  dout_valid <= din_valid each cycle.
//  Top mode (k=DATA_W): dataout = datain.
//  sof with din_valid=0: ignored.
// TESTING
//  1 Reset, datain=5'b10111 valid -> next cycle dataout=5'b11000, dout_valid=1, mode=0.
//  2 sel low for 8 cycles (DEBOUNCE_CYC=16) -> no event, mode_pending=0.
//    sel low for 40 cycles -> exactly one event, mode_pending=1.
//  3 One press, then a valid symbol with sof=0 -> mode stays 0.
//    Next sof symbol datain=5'b10111 -> mode=1, dataout=5'b11100, mode_changed 1 cycle.
//  4 Four presses, then sof (NUM_MODES=4) -> wraps to 0, mode_pending=0, no mode_changed.
//    Five presses -> mode=1.
//  5 Press event in the same cycle as sof, from mode 0 -> mode=1 applied, next_mode=2,
//    mode_pending=1.
//  6 rst_n low mid-frame with mode=3 and a pending request -> all outputs and mode 0 at once,
//    and the pending request is discarded.

Source files
------------

// File: rtl/pam_mode_if.sv
// Symbol-path bundle between the symbol generator, the PAM mode controller and the DAC serialiser.
// The master drives the button and the LSB-aligned symbols; the slave returns DAC words and mode status.
interface pam_mode_if #(
  parameter int DATA_W   = 5,
  parameter int MIN_BITS = 2
);
  localparam int NUM_MODES = DATA_W - MIN_BITS + 1;
  localparam int MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  logic              sel;
  logic [DATA_W-1:0] datain;
  logic              din_valid;
  logic              sof;
  logic [DATA_W-1:0] dataout;
  logic              dout_valid;
  logic [MODE_W-1:0] mode;
  logic              mode_pending;
  logic              mode_changed;

  modport master (
    output sel, datain, din_valid, sof,
    input  dataout, dout_valid, mode, mode_pending, mode_changed
  );

  modport slave (
    input  sel, datain, din_valid, sof,
    output dataout, dout_valid, mode, mode_pending, mode_changed
  );
endinterface

// File: rtl/pam_mode_ctrl.sv
// PAM-level selector: debounced pushbutton steps the bits/symbol, the change is taken at a frame
// start, and each symbol is left-justified onto the DAC word one cycle later.
module pam_mode_ctrl #(
  parameter int DATA_W       = 5,
  parameter int MIN_BITS     = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int APPLY_AT_SOF = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  pam_mode_if.slave   bus
);
  localparam int NUM_MODES = DATA_W - MIN_BITS + 1;
  localparam int MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int CNT_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [CNT_W-1:0]       r_db_cnt;
  logic [MODE_W-1:0]      r_next_mode;
  logic [MODE_W-1:0]      r_mode;
  logic                   r_mode_changed;
  logic [DATA_W-1:0]      r_dataout_p1;
  logic                   r_vld_p1;

  logic                   w_sel_s;
  logic                   w_press;
  logic                   w_apply;
  logic [MODE_W-1:0]      w_mode_eff;

  // Keep the low MIN_BITS+m bits and move them to the top of the DAC word; low bits zero-fill.
  function automatic logic [DATA_W-1:0] f_left_justify(input logic [DATA_W-1:0] d,
                                                       input logic [MODE_W-1:0] m);
    int k;
    k = MIN_BITS + int'(m);
    return DATA_W'(d << (DATA_W - k));
  endfunction

  function automatic logic [MODE_W-1:0] f_mode_inc(input logic [MODE_W-1:0] m);
    return (m == MODE_MAX) ? '0 : m + MODE_W'(1);
  endfunction

  assign w_sel_s = r_sync[SYNC_STAGES-1];
  // A press is the accepted 1->0 transition of the debounced level; releases do nothing.
  assign w_press = r_stable && !w_sel_s && (r_db_cnt == CNT_MAX);
  assign w_apply = (APPLY_AT_SOF != 0) ? (bus.din_valid && bus.sof) : 1'b1;
  // On the applying sof symbol the freshly loaded mode already governs the format.
  assign w_mode_eff = ((APPLY_AT_SOF != 0) && w_apply) ? r_next_mode : r_mode;

  // Button synchroniser and debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '1;
      r_stable <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.sel};
      if (w_sel_s == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == CNT_MAX) begin
        r_stable <= w_sel_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end
  end

  // Mode request / apply; the apply uses next_mode before this cycle's press updates it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_mode    <= '0;
      r_mode         <= '0;
      r_mode_changed <= 1'b0;
    end else begin
      if (w_press) begin
        r_next_mode <= f_mode_inc(r_next_mode);
      end
      if (w_apply) begin
        r_mode <= r_next_mode;
      end
      r_mode_changed <= w_apply && (r_next_mode != r_mode);
    end
  end

  // Stage p1: formatted symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataout_p1 <= '0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_vld_p1 <= bus.din_valid;
      if (bus.din_valid) begin
        r_dataout_p1 <= f_left_justify(bus.datain, w_mode_eff);
      end
    end
  end

  assign bus.dataout      = r_dataout_p1;
  assign bus.dout_valid   = r_vld_p1;
  assign bus.mode         = r_mode;
  assign bus.mode_pending = (r_next_mode != r_mode);
  assign bus.mode_changed = r_mode_changed;
endmodule

// File: tb/tb_pam_mode_ctrl.sv
// Directed bench for pam_mode_ctrl with default parameters (DATA_W=5, MIN_BITS=2, DEBOUNCE_CYC=16).
module tb_pam_mode_ctrl;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pam_mode_if #(.DATA_W(5), .MIN_BITS(2)) bus();

  pam_mode_ctrl #(
    .DATA_W(5), .MIN_BITS(2), .DEBOUNCE_CYC(16), .SYNC_STAGES(2), .APPLY_AT_SOF(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.sel       = 1'b1;
    bus.datain    = '0;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [4:0] d, input logic s);
    bus.datain    = d;
    bus.din_valid = 1'b1;
    bus.sof       = s;
    tick();
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic press();
    bus.sel = 1'b0;
    repeat (24) tick();
    bus.sel = 1'b1;
    repeat (24) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.dataout !== 5'b00000) begin errors++; $display("FAIL reset_dataout: got %b expected %b", bus.dataout, 5'b00000); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", bus.dout_valid); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.mode_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", bus.mode_pending); end
    checks++; if (bus.mode_changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b expected 0", bus.mode_changed); end
    send(5'b10111, 1'b0);
    checks++; if (bus.dataout !== 5'b11000) begin errors++; $display("FAIL t1_dataout: got %b expected %b", bus.dataout, 5'b11000); end
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL t1_dout_valid: got %b expected 1", bus.dout_valid); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL t1_mode: got %0d expected 0", bus.mode); end
    tick();
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop: got %b expected 0", bus.dout_valid); end
    checks++; if (bus.dataout !== 5'b11000) begin errors++; $display("FAIL t1_hold: got %b expected %b", bus.dataout, 5'b11000); end
  endtask

  task automatic test_debounce();
    do_reset();
    bus.sel = 1'b0;
    repeat (8) tick();
    bus.sel = 1'b1;
    repeat (24) tick();
    checks++; if (bus.mode_pending !== 1'b0) begin errors++; $display("FAIL t2_glitch: got pending=%b expected 0", bus.mode_pending); end
    bus.sel = 1'b0;
    repeat (17) tick();
    checks++; if (bus.mode_pending !== 1'b0) begin errors++; $display("FAIL t2_early: got pending=%b expected 0", bus.mode_pending); end
    tick();
    checks++; if (bus.mode_pending !== 1'b1) begin errors++; $display("FAIL t2_accept: got pending=%b expected 1", bus.mode_pending); end
    repeat (22) tick();
    checks++; if (bus.mode_pending !== 1'b1) begin errors++; $display("FAIL t2_pending40: got pending=%b expected 1", bus.mode_pending); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL t2_mode_held: got %0d expected 0", bus.mode); end
    bus.sel = 1'b1;
    repeat (24) tick();
    send(5'b10111, 1'b1);
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL t2_one_event: got mode=%0d expected 1", bus.mode); end
    checks++; if (bus.mode_pending !== 1'b0) begin errors++; $display("FAIL t2_release_ignored: got pending=%b expected 0", bus.mode_pending); end
  endtask

  task automatic test_apply_at_sof();
    do_reset();
    press();
    send(5'b10111, 1'b0);
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL t3_no_sof_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.dataout !== 5'b11000) begin errors++; $display("FAIL t3_no_sof_data: got %b expected %b", bus.dataout, 5'b11000); end
    checks++; if (bus.mode_pending !== 1'b1) begin errors++; $display("FAIL t3_pending: got %b expected 1", bus.mode_pending); end
    bus.datain = 5'b10111; bus.din_valid = 1'b0; bus.sof = 1'b1;
    tick();
    bus.sof = 1'b0;
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL t3_sof_invalid: got mode=%0d expected 0", bus.mode); end
    send(5'b10111, 1'b1);
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL t3_mode: got %0d expected 1", bus.mode); end
    checks++; if (bus.dataout !== 5'b11100) begin errors++; $display("FAIL t3_dataout: got %b expected %b", bus.dataout, 5'b11100); end
    checks++; if (bus.mode_changed !== 1'b1) begin errors++; $display("FAIL t3_changed: got %b expected 1", bus.mode_changed); end
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL t3_changed_align: got dout_valid=%b expected 1", bus.dout_valid); end
    tick();
    checks++; if (bus.mode_changed !== 1'b0) begin errors++; $display("FAIL t3_changed_pulse: got %b expected 0", bus.mode_changed); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (4) press();
    checks++; if (bus.mode_pending !== 1'b0) begin errors++; $display("FAIL t4_wrap_pending: got %b expected 0", bus.mode_pending); end
    send(5'b10111, 1'b1);
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL t4_wrap_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.mode_changed !== 1'b0) begin errors++; $display("FAIL t4_wrap_changed: got %b expected 0", bus.mode_changed); end
    checks++; if (bus.dataout !== 5'b11000) begin errors++; $display("FAIL t4_wrap_data: got %b expected %b", bus.dataout, 5'b11000); end
    repeat (5) press();
    checks++; if (bus.mode_pending !== 1'b1) begin errors++; $display("FAIL t4_five_pending: got %b expected 1", bus.mode_pending); end
    send(5'b10111, 1'b1);
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL t4_five_mode: got %0d expected 1", bus.mode); end
    checks++; if (bus.mode_changed !== 1'b1) begin errors++; $display("FAIL t4_five_changed: got %b expected 1", bus.mode_changed); end
  endtask

  task automatic test_press_at_sof();
    do_reset();
    press();
    bus.sel = 1'b0;
    repeat (17) tick();
    send(5'b10111, 1'b1);
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL t5_mode: got %0d expected 1", bus.mode); end
    checks++; if (bus.mode_pending !== 1'b1) begin errors++; $display("FAIL t5_pending: got %b expected 1", bus.mode_pending); end
    checks++; if (bus.dataout !== 5'b11100) begin errors++; $display("FAIL t5_dataout: got %b expected %b", bus.dataout, 5'b11100); end
    bus.sel = 1'b1;
    repeat (24) tick();
    send(5'b10111, 1'b1);
    checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL t5_next_mode: got %0d expected 2", bus.mode); end
    checks++; if (bus.dataout !== 5'b01110) begin errors++; $display("FAIL t5_mode2_data: got %b expected %b", bus.dataout, 5'b01110); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    repeat (3) press();
    send(5'b10111, 1'b1);
    checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL t6_top_mode: got %0d expected 3", bus.mode); end
    checks++; if (bus.dataout !== 5'b10111) begin errors++; $display("FAIL t6_top_data: got %b expected %b", bus.dataout, 5'b10111); end
    press();
    send(5'b01010, 1'b0);
    checks++; if (bus.dataout !== 5'b01010) begin errors++; $display("FAIL t6_top_data2: got %b expected %b", bus.dataout, 5'b01010); end
    checks++; if (bus.mode_pending !== 1'b1) begin errors++; $display("FAIL t6_pre_pending: got %b expected 1", bus.mode_pending); end
    bus.datain = 5'b11111; bus.din_valid = 1'b1; bus.sof = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.dataout !== 5'b00000) begin errors++; $display("FAIL t6_rst_dataout: got %b expected %b", bus.dataout, 5'b00000); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_valid: got %b expected 0", bus.dout_valid); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL t6_rst_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.mode_pending !== 1'b0) begin errors++; $display("FAIL t6_rst_pending: got %b expected 0", bus.mode_pending); end
    checks++; if (bus.mode_changed !== 1'b0) begin errors++; $display("FAIL t6_rst_changed: got %b expected 0", bus.mode_changed); end
    bus.din_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send(5'b10111, 1'b1);
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL t6_discard_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.mode_changed !== 1'b0) begin errors++; $display("FAIL t6_discard_changed: got %b expected 0", bus.mode_changed); end
    checks++; if (bus.dataout !== 5'b11000) begin errors++; $display("FAIL t6_discard_data: got %b expected %b", bus.dataout, 5'b11000); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    test_reset();
    test_debounce();
    test_apply_at_sof();
    test_wrap();
    test_press_at_sof();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
